aes128_axi_slv: RTL and testbench
=================================

Name: aes128_axi_slv

Overview:
- AMBA AXI slave front-end for the AES-128 core; directly downstream of the USB-to-AXI transactor in the AES test design.
- Accepts AXI write and read bursts and maps them onto a 32-bit register bank (key, text-in, control, status, text-out).
- Drives a fixed-latency-agnostic AES-128 core through a start/done handshake and latches the core result for read-back.

Parameters:
- AXI_WIDTH_CID, 4, channel (master) ID width in bits
- AXI_WIDTH_ID, 4, transaction ID width in bits
- AXI_WIDTH_SID, AXI_WIDTH_CID+AXI_WIDTH_ID, full slave-side ID width
- AXI_WIDTH_AD, 32, address width
- AXI_WIDTH_DA, 32, data width; only 32 is supported

Ports:
- ACLK  input  1  clock for all logic
- ARESET  input  1  synchronous, active-high reset
- AWID  input  AXI_WIDTH_SID  write address ID
- AWADDR  input  AXI_WIDTH_AD  write start address
- AWLEN  input  4  write beats minus 1
- AWSIZE  input  3  write beat size
- AWBURST  input  2  write burst type
- AWVALID  input  1  write address valid
- AWREADY  output  1  write address ready
- WID  input  AXI_WIDTH_SID  write data ID (ignored)
- WDATA  input  32  write data
- WSTRB  input  4  write byte strobes
- WLAST  input  1  last write beat
- WVALID  input  1  write data valid
- WREADY  output  1  write data ready
- BID  output  AXI_WIDTH_SID  write response ID
- BRESP  output  2  write response code
- BVALID  output  1  write response valid
- BREADY  input  1  write response ready
- ARID  input  AXI_WIDTH_SID  read address ID
- ARADDR  input  AXI_WIDTH_AD  read start address
- ARLEN  input  4  read beats minus 1
- ARSIZE  input  3  read beat size
- ARBURST  input  2  read burst type
- ARVALID  input  1  read address valid
- ARREADY  output  1  read address ready
- RID  output  AXI_WIDTH_SID  read data ID
- RDATA  output  32  read data
- RRESP  output  2  read response code
- RLAST  output  1  last read beat
- RVALID  output  1  read data valid
- RREADY  input  1  read data ready
- CORE_KEY  output  128  key to AES core
- CORE_TEXT  output  128  input block to AES core
- CORE_ENC  output  1  1 = encrypt, 0 = decrypt
- CORE_START  output  1  one-cycle start pulse
- CORE_DONE  input  1  one-cycle done pulse from core
- CORE_RESULT  input  128  core output, valid with CORE_DONE

Behaviour:
- Reset and ports:
  - Clock is ACLK; reset is ARESET, synchronous and active-high.
  - Reset clears all registers, CORE_START, AWREADY/ARREADY, WREADY, BVALID, RVALID and RLAST to 0. ID and response outputs reset to 0.
  - Reset mid-burst abandons the burst; no response is issued.
- Register map (decode on addr[5:2]; upper address bits ignored):
  - 0x00-0x0C KEY: 0x00 holds bits [127:96].
  - 0x10-0x1C TEXT_IN: same word ordering as KEY.
  - 0x20 CTRL: bit0 START (write-1, reads 0); bit1 ENC (R/W).
  - 0x24 STATUS: bit0 BUSY (RO); bit1 DONE (sticky; write-1 clears).
  - 0x30-0x3C TEXT_OUT: read-only.
  - Unmapped offsets read 0; writes to them are dropped with OKAY.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: AWREADY=1. On AWVALID, capture AWID, address, AWLEN, error flag -> W_DATA.
  - W_DATA: WREADY=1. Each accepted beat updates byte lanes per WSTRB.
  - Address steps +4 for INCR and holds for FIXED. Offset wraps modulo 0x40.
  - After AWLEN+1 beats -> W_RESP with BVALID=1 and BID=captured AWID. Hold until BREADY, then -> W_IDLE.
  - WLAST missing or early vs the beat count sets SLVERR; the beat count alone ends the burst.
- Read FSM (R_IDLE, R_DATA):
  - R_IDLE: ARREADY=1. Capture the request -> R_DATA.
  - R_DATA: RDATA is registered from the map. RVALID holds until RREADY, and the next beat is presented the cycle after the handshake.
  - RLAST=1 on beat ARLEN. RID=captured ARID. After the last handshake -> R_IDLE.
- Errors (BRESP/RRESP=SLVERR 2'b10, writes suppressed for the whole burst):
  - AxSIZE!=2.
  - AxBURST not FIXED/INCR.
  - Any write beat to KEY, TEXT_IN or CTRL.START while BUSY=1; the offending beat is dropped and SLVERR is reported.
  - Otherwise the response is OKAY.
- Core handshake:
  - An accepted CTRL write with bit0=1 and BUSY=0 pulses CORE_START high for exactly 1 cycle, on the cycle after the beat. The same cycle sets BUSY=1 and clears DONE.
  - CORE_KEY, CORE_TEXT and CORE_ENC are driven continuously from the registers. They are frozen while BUSY because writes are blocked.
  - CORE_DONE with BUSY=1 latches CORE_RESULT into TEXT_OUT, sets DONE=1 and clears BUSY on the next edge. CORE_DONE with BUSY=0 is ignored.
- Simultaneous events:
  - Read and write channels run independently.
  - A read of STATUS or TEXT_OUT in the same cycle as the CORE_DONE update returns the pre-update value.
  - A DONE write-1-clear coincident with CORE_DONE leaves DONE=1.

Test Plan:
- Reset: hold ARESET 3 cycles mid-burst, release -> all valid/ready 0 during reset, AWREADY=ARREADY=1 one cycle after release, KEY reads 0x00000000.
- INCR 4-beat write to 0x00, data 2b7e1516/28aed2a6/abf71588/09cf4f3c, AWID 0x13 -> BRESP OKAY, BID 0x13. 4-beat read returns the same words with RLAST only on beat 4.
- Write TEXT_IN 3243f6a8/885a308d/313198a2/e0370734, then CTRL=0x3 -> single-cycle CORE_START, CORE_ENC=1, CORE_KEY=2b7e...4f3c. The core model returns 3925841d02dc09fbdc118597196a0b32 after 12 cycles -> STATUS=0x2, TEXT_OUT reads back the four result words.
- During BUSY, write KEY 0x00=0xffffffff and CTRL=0x1 -> SLVERR for both, KEY unchanged, no second CORE_START.
- TEXT_IN 0x10=0x11223344, then write 0xdeadbeef with WSTRB=0x3 -> reads 0x1122beef.
- Write with AWSIZE=1, and write with AWBURST=WRAP, each to 0x00 -> SLVERR, KEY unchanged. Read of 0x28 -> 0x00000000, OKAY. Write with early WLAST -> SLVERR.

Source files
------------

// File: rtl/aes128_axi_slv.sv
// AXI slave front-end for the AES-128 core.
// Maps AXI write and read bursts onto a 32-bit register bank, drives the core through a
// start/done handshake, and latches the core result so it can be read back.
// Register map (word index = addr[5:2]):
//   0-3 KEY, 4-7 TEXT_IN (word 0 = bits [127:96]), 8 CTRL {ENC, START},
//   9 STATUS {DONE, BUSY}, 12-15 TEXT_OUT (read-only); other offsets read 0.
// Ports:
//   ACLK, ARESET        clock and synchronous active-high reset
//   AW*/W*/B*           AXI write address, data and response channels
//   AR*/R*              AXI read address and data channels
//   CORE_KEY/TEXT/ENC   operands held steady for the core
//   CORE_START          one-cycle start pulse to the core
//   CORE_DONE/RESULT    completion pulse and result from the core
module aes128_axi_slv #(
  parameter int unsigned AXI_WIDTH_CID = 4,
  parameter int unsigned AXI_WIDTH_ID  = 4,
  parameter int unsigned AXI_WIDTH_SID = AXI_WIDTH_CID + AXI_WIDTH_ID,
  parameter int unsigned AXI_WIDTH_AD  = 32,
  parameter int unsigned AXI_WIDTH_DA  = 32
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [AXI_WIDTH_SID-1:0] AWID,
  input  logic [AXI_WIDTH_AD-1:0]  AWADDR,
  input  logic [3:0]               AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [AXI_WIDTH_SID-1:0] WID,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [AXI_WIDTH_SID-1:0] BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [AXI_WIDTH_SID-1:0] ARID,
  input  logic [AXI_WIDTH_AD-1:0]  ARADDR,
  input  logic [3:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [AXI_WIDTH_SID-1:0] RID,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [127:0]             CORE_KEY,
  output logic [127:0]             CORE_TEXT,
  output logic                     CORE_ENC,
  output logic                     CORE_START,
  input  logic                     CORE_DONE,
  input  logic [127:0]             CORE_RESULT
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [3:0] IdxCtrl    = 4'h8;
  localparam logic [3:0] IdxStatus  = 4'h9;

  typedef enum logic [1:0] {StWIdle, StWData, StWResp} wstate_e;
  typedef enum logic       {StRIdle, StRData} rstate_e;

  // Register bank
  logic [31:0] key_q  [4];
  logic [31:0] text_q [4];
  logic [31:0] tout_q [4];
  logic        enc_q, busy_q, done_q, core_start_q;

  // Write channel state
  wstate_e                  wstate_q;
  logic [3:0]               widx_q, wlen_q, wcnt_q;
  logic                     wfixed_q, werr_q;
  logic                     awready_q, wready_q, bvalid_q;
  logic [AXI_WIDTH_SID-1:0] bid_q;
  logic [1:0]               bresp_q;

  // Read channel state
  rstate_e                  rstate_q;
  logic [3:0]               ridx_q, rlen_q, rcnt_q;
  logic                     rfixed_q;
  logic                     arready_q, rvalid_q, rlast_q;
  logic [AXI_WIDTH_SID-1:0] rid_q;
  logic [1:0]               rresp_q;
  logic [31:0]              rdata_q;

  function automatic logic [31:0] reg_word(input logic [3:0] idx);
    logic [31:0] w;
    w = '0;
    case (idx)
      4'h0, 4'h1, 4'h2, 4'h3: w = key_q[idx[1:0]];
      4'h4, 4'h5, 4'h6, 4'h7: w = text_q[idx[1:0]];
      IdxCtrl:                w = {30'd0, enc_q, 1'b0};
      IdxStatus:              w = {30'd0, done_q, busy_q};
      4'hc, 4'hd, 4'he, 4'hf: w = tout_q[idx[1:0]];
      default:                w = '0;
    endcase
    return w;
  endfunction

  logic [31:0] wmask;
  logic        wbeat, wlast_exp, wlast_bad, wblock, wen;
  logic [3:0]  wnext_idx, rnext_idx;

  always_comb begin
    wmask     = {{8{WSTRB[3]}}, {8{WSTRB[2]}}, {8{WSTRB[1]}}, {8{WSTRB[0]}}};
    wbeat     = WVALID && wready_q;
    wlast_exp = (wcnt_q == wlen_q);
    wlast_bad = (WLAST != wlast_exp);
    // Operands and START are locked while the core is running.
    wblock    = busy_q && ((widx_q < 4'd8) ||
                           (widx_q == IdxCtrl && WSTRB[0] && WDATA[0]));
    wen       = wbeat && !werr_q && !wblock && !wlast_bad;
    wnext_idx = wfixed_q ? widx_q : widx_q + 4'd1;
    rnext_idx = rfixed_q ? ridx_q : ridx_q + 4'd1;
  end

  // Write FSM, register bank and core handshake
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q     <= StWIdle;
      widx_q       <= '0;
      wlen_q       <= '0;
      wcnt_q       <= '0;
      wfixed_q     <= 1'b0;
      werr_q       <= 1'b0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bid_q        <= '0;
      bresp_q      <= RespOkay;
      enc_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        key_q[i]  <= '0;
        text_q[i] <= '0;
        tout_q[i] <= '0;
      end
    end else begin
      core_start_q <= 1'b0;
      unique case (wstate_q)
        StWIdle: begin
          if (AWVALID && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            widx_q    <= AWADDR[5:2];
            wlen_q    <= AWLEN;
            wcnt_q    <= '0;
            wfixed_q  <= (AWBURST == 2'b00);
            werr_q    <= (AWSIZE != 3'd2) || AWBURST[1];
            bid_q     <= AWID;
            wstate_q  <= StWData;
          end else begin
            awready_q <= 1'b1;
          end
        end
        StWData: begin
          if (wbeat) begin
            if (wblock || wlast_bad) werr_q <= 1'b1;
            widx_q <= wnext_idx;
            wcnt_q <= wcnt_q + 4'd1;
            // The beat count alone ends the burst; WLAST only affects the response.
            if (wlast_exp) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q || wblock || wlast_bad) ? RespSlverr : RespOkay;
              wstate_q <= StWResp;
            end
          end
        end
        StWResp: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= StWIdle;
          end
        end
        default: wstate_q <= StWIdle;
      endcase

      if (wen) begin
        if (widx_q < 4'd4) begin
          key_q[widx_q[1:0]] <= (key_q[widx_q[1:0]] & ~wmask) | (WDATA & wmask);
        end else if (widx_q < 4'd8) begin
          text_q[widx_q[1:0]] <= (text_q[widx_q[1:0]] & ~wmask) | (WDATA & wmask);
        end else if (widx_q == IdxCtrl) begin
          if (WSTRB[0]) begin
            enc_q <= WDATA[1];
            if (WDATA[0]) begin
              core_start_q <= 1'b1;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
            end
          end
        end else if (widx_q == IdxStatus) begin
          if (WSTRB[0] && WDATA[1]) done_q <= 1'b0;
        end
      end

      // Placed last so a coincident DONE write-1-clear loses to completion.
      if (CORE_DONE && busy_q) begin
        tout_q[0] <= CORE_RESULT[127:96];
        tout_q[1] <= CORE_RESULT[95:64];
        tout_q[2] <= CORE_RESULT[63:32];
        tout_q[3] <= CORE_RESULT[31:0];
        done_q    <= 1'b1;
        busy_q    <= 1'b0;
      end
    end
  end

  // Read FSM; RDATA is sampled from the bank, so it reflects pre-update values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q  <= StRIdle;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rfixed_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
    end else begin
      unique case (rstate_q)
        StRIdle: begin
          if (ARVALID && arready_q) begin
            arready_q <= 1'b0;
            ridx_q    <= ARADDR[5:2];
            rlen_q    <= ARLEN;
            rcnt_q    <= '0;
            rfixed_q  <= (ARBURST == 2'b00);
            rid_q     <= ARID;
            rresp_q   <= ((ARSIZE != 3'd2) || ARBURST[1]) ? RespSlverr : RespOkay;
            rdata_q   <= reg_word(ARADDR[5:2]);
            rvalid_q  <= 1'b1;
            rlast_q   <= (ARLEN == 4'd0);
            rstate_q  <= StRData;
          end else begin
            arready_q <= 1'b1;
          end
        end
        StRData: begin
          if (RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= StRIdle;
            end else begin
              ridx_q  <= rnext_idx;
              rcnt_q  <= rcnt_q + 4'd1;
              rdata_q <= reg_word(rnext_idx);
              rlast_q <= ((rcnt_q + 4'd1) == rlen_q);
            end
          end
        end
        default: rstate_q <= StRIdle;
      endcase
    end
  end

  assign AWREADY    = awready_q;
  assign WREADY     = wready_q;
  assign BVALID     = bvalid_q;
  assign BID        = bid_q;
  assign BRESP      = bresp_q;
  assign ARREADY    = arready_q;
  assign RVALID     = rvalid_q;
  assign RLAST      = rlast_q;
  assign RID        = rid_q;
  assign RRESP      = rresp_q;
  assign RDATA      = rdata_q;
  assign CORE_KEY   = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign CORE_TEXT  = {text_q[0], text_q[1], text_q[2], text_q[3]};
  assign CORE_ENC   = enc_q;
  assign CORE_START = core_start_q;

  // Address bits outside the 64-byte window and the write-data ID carry no meaning here.
  logic unused;
  assign unused = ^{WID, AWADDR[AXI_WIDTH_AD-1:6], AWADDR[1:0],
                    ARADDR[AXI_WIDTH_AD-1:6], ARADDR[1:0]};

endmodule

// File: tb/tb_aes128_axi_slv.sv
module tb_aes128_axi_slv;
  localparam int SID = 8;

  logic           ACLK = 1'b0;
  logic           ARESET = 1'b1;
  logic [SID-1:0] AWID = '0, WID = '0, ARID = '0;
  logic [31:0]    AWADDR = '0, ARADDR = '0, WDATA = '0;
  logic [3:0]     AWLEN = '0, ARLEN = '0, WSTRB = '0;
  logic [2:0]     AWSIZE = '0, ARSIZE = '0;
  logic [1:0]     AWBURST = '0, ARBURST = '0;
  logic           AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0, ARVALID = 1'b0;
  logic           BREADY = 1'b1, RREADY = 1'b0;
  logic           AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
  logic [SID-1:0] BID, RID;
  logic [1:0]     BRESP, RRESP;
  logic [31:0]    RDATA;
  logic [127:0]   CORE_KEY, CORE_TEXT;
  logic           CORE_ENC, CORE_START;
  logic           CORE_DONE = 1'b0;
  logic [127:0]   CORE_RESULT = '0;

  aes128_axi_slv dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CORE_KEY(CORE_KEY), .CORE_TEXT(CORE_TEXT), .CORE_ENC(CORE_ENC), .CORE_START(CORE_START),
    .CORE_DONE(CORE_DONE), .CORE_RESULT(CORE_RESULT)
  );

  always #5 ACLK = ~ACLK;

  localparam logic [127:0] SpecKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SpecText = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] SpecRes  = 128'h3925841d02dc09fbdc118597196a0b32;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Core model: fixed latency, result looked up from the operands.
  int           core_lat = 12;
  int           core_timer = 0;
  int           n_starts = 0;
  int           wide_pulses = 0;
  int           done_seen = 0;
  int           stray_req = 0;
  int           stray_ack = 0;
  logic         start_prev = 1'b0;
  logic [127:0] cap_key = '0, cap_text = '0, core_res = '0;
  logic         cap_enc = 1'b0;

  always @(negedge ACLK) begin
    CORE_DONE = 1'b0;
    if (stray_req != stray_ack) begin
      stray_ack   = stray_req;
      CORE_DONE   = 1'b1;
      CORE_RESULT = {4{32'hdeaddead}};
    end else if (core_timer > 0) begin
      core_timer--;
      if (core_timer == 0) begin
        CORE_DONE   = 1'b1;
        CORE_RESULT = core_res;
        done_seen++;
      end
    end
    if (CORE_START) begin
      if (start_prev) wide_pulses++;
      n_starts++;
      cap_key    = CORE_KEY;
      cap_text   = CORE_TEXT;
      cap_enc    = CORE_ENC;
      core_res   = (CORE_TEXT == SpecText) ? SpecRes : (CORE_KEY ^ CORE_TEXT);
      core_timer = core_lat;
    end
    start_prev = CORE_START;
  end

  // Register-map reference model
  logic [31:0] m_key [4];
  logic [31:0] m_text [4];
  logic [31:0] m_out [4];
  logic        m_enc, m_busy, m_done;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_key[i] = '0; m_text[i] = '0; m_out[i] = '0;
    end
    m_enc = 1'b0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    if (idx < 4) return m_key[idx[1:0]];
    if (idx < 8) return m_text[idx[1:0]];
    if (idx == 4'h8) return {30'd0, m_enc, 1'b0};
    if (idx == 4'h9) return {30'd0, m_done, m_busy};
    if (idx >= 4'hc) return m_out[idx[1:0]];
    return 32'd0;
  endfunction

  task automatic m_beat(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] s,
                        output bit blk);
    logic [31:0] msk;
    msk = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    blk = m_busy && (idx < 8 || (idx == 4'h8 && s[0] && d[0]));
    if (!blk) begin
      if (idx < 4) m_key[idx[1:0]] = (m_key[idx[1:0]] & ~msk) | (d & msk);
      else if (idx < 8) m_text[idx[1:0]] = (m_text[idx[1:0]] & ~msk) | (d & msk);
      else if (idx == 4'h8 && s[0]) begin
        m_enc = d[1];
        if (d[0]) begin m_busy = 1'b1; m_done = 1'b0; end
      end else if (idx == 4'h9 && s[0] && d[1]) m_done = 1'b0;
    end
  endtask

  task automatic wait_rdy(input int sel, output bit ok);
    bit hs;
    int t;
    t = 0;
    do begin
      case (sel)
        0: hs = AWREADY;
        1: hs = WREADY;
        default: hs = ARREADY;
      endcase
      @(posedge ACLK); #1;
      t++;
    end while (!hs && t < 200);
    ok = hs;
  endtask

  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  // Write burst from wd/ws; WLAST asserted on beat last_at (-1: never).
  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int last_at,
                           output logic [1:0] resp);
    bit ok, err, blk, got;
    logic [3:0] idx;
    logic [7:0] bid_v;
    int t;
    resp = 2'b11;
    err = (size != 3'd2) || (burst > 2'd1);
    idx = addr[5:2];
    AWID = id; AWADDR = addr; AWLEN = len[3:0]; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    wait_rdy(0, ok);
    AWVALID = 1'b0;
    if (!ok) begin chk("aw_timeout", 0, 1); return; end
    for (int b = 0; b <= len; b++) begin
      WID = id; WDATA = wd[b]; WSTRB = ws[b]; WLAST = (b == last_at); WVALID = 1'b1;
      wait_rdy(1, ok);
      if (!ok) begin WVALID = 1'b0; chk("w_timeout", 0, 1); return; end
      if (!err) begin
        if ((b == last_at) != (b == len)) err = 1'b1;
        else begin
          m_beat(idx, wd[b], ws[b], blk);
          if (blk) err = 1'b1;
        end
      end
      if (burst == 2'b01) idx = idx + 4'd1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    got = 1'b0; t = 0;
    while (!got && t < 200) begin
      if (BVALID) begin got = 1'b1; resp = BRESP; bid_v = BID; end
      @(posedge ACLK); #1;
      t++;
    end
    if (!got) begin chk("b_timeout", 0, 1); return; end
    chk("wr_bresp", resp, err ? 2'b10 : 2'b00);
    chk("wr_bid", bid_v, id);
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          output logic [31:0] d0, output logic [1:0] r0);
    bit ok, err, hs;
    logic [3:0] idx;
    logic [31:0] d;
    logic [1:0] rs;
    logic l;
    logic [7:0] ri;
    int t;
    d0 = '0; r0 = 2'b11;
    err = (size != 3'd2) || (burst > 2'd1);
    idx = addr[5:2];
    ARID = id; ARADDR = addr; ARLEN = len[3:0]; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    wait_rdy(2, ok);
    ARVALID = 1'b0;
    if (!ok) begin chk("ar_timeout", 0, 1); return; end
    for (int b = 0; b <= len; b++) begin
      hs = 1'b0; t = 0;
      while (!hs && t < 200) begin
        RREADY = 1'($urandom_range(0, 1));
        hs = RVALID && RREADY;
        if (hs) begin d = RDATA; rs = RRESP; l = RLAST; ri = RID; end
        @(posedge ACLK); #1;
        t++;
      end
      RREADY = 1'b0;
      if (!hs) begin chk("r_timeout", 0, 1); return; end
      if (!err) chk("rd_data", d, m_read(idx));
      chk("rd_last", l, (b == len));
      chk("rd_resp", rs, err ? 2'b10 : 2'b00);
      chk("rd_id", ri, id);
      if (b == 0) begin d0 = d; r0 = rs; end
      if (burst == 2'b01) idx = idx + 4'd1;
    end
  endtask

  task automatic wait_core(input int prev);
    int t;
    t = 0;
    while (done_seen == prev && t < 500) begin @(posedge ACLK); #1; t++; end
    chk("core_done_seen", done_seen != prev, 1);
    m_out[0] = core_res[127:96]; m_out[1] = core_res[95:64];
    m_out[2] = core_res[63:32];  m_out[3] = core_res[31:0];
    m_done = 1'b1; m_busy = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [1:0]  resp, rr;
    logic [31:0] rd;
    bit ok;
    int prev;

    vecs[0] = '{32'h10, 32'h11223344, 4'hf, 2'b00, 32'h11223344};
    vecs[1] = '{32'h10, 32'hdeadbeef, 4'h3, 2'b00, 32'h1122beef};
    vecs[2] = '{32'h28, 32'h12345678, 4'hf, 2'b00, 32'h00000000};
    vecs[3] = '{32'h30, 32'hffffffff, 4'hf, 2'b00, 32'h3925841d};
    vecs[4] = '{32'h24, 32'h00000002, 4'hf, 2'b00, 32'h00000000};
    vecs[5] = '{32'h20, 32'h00000000, 4'hf, 2'b00, 32'h00000000};
    vecs[6] = '{32'h20, 32'h00000002, 4'h1, 2'b00, 32'h00000002};
    vecs[7] = '{32'h4c, 32'ha5a5a5a5, 4'hf, 2'b00, 32'ha5a5a5a5};
    vecs[8] = '{32'h1c, 32'h77000000, 4'h8, 2'b00, 32'h77370734};
    vecs[9] = '{32'h0c, 32'h00000000, 4'h0, 2'b00, 32'ha5a5a5a5};

    m_reset();
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Reset in the middle of a write burst
    AWID = 8'h55; AWADDR = 32'h0; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    wait_rdy(0, ok);
    AWVALID = 1'b0;
    WDATA = 32'hcafef00d; WSTRB = 4'hf; WLAST = 1'b0; WVALID = 1'b1;
    wait_rdy(1, ok);
    WVALID = 1'b0;
    ARESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge ACLK); #1;
      chk("rst_hold_ctrl", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, CORE_START}, 7'd0);
      chk("rst_hold_ids", {BID, RID, BRESP, RRESP}, 20'd0);
    end
    ARESET = 1'b0;
    m_reset();
    @(posedge ACLK); #1;
    chk("rst_release_ready", {AWREADY, ARREADY}, 2'b11);
    chk("rst_no_bresp", BVALID, 1'b0);
    axi_read(8'h01, 32'h0, 0, 3'd2, 2'b01, rd, rr);
    chk("rst_key0", rd, 32'h0);

    // KEY INCR burst and read-back
    wd[0] = 32'h2b7e1516; wd[1] = 32'h28aed2a6; wd[2] = 32'habf71588; wd[3] = 32'h09cf4f3c;
    for (int i = 0; i < 4; i++) ws[i] = 4'hf;
    axi_write(8'h13, 32'h0, 3, 3'd2, 2'b01, 3, resp);
    chk("key_bresp", resp, 2'b00);
    axi_read(8'h13, 32'h0, 3, 3'd2, 2'b01, rd, rr);
    chk("key_word0", rd, 32'h2b7e1516);

    // TEXT_IN then start encryption
    wd[0] = 32'h3243f6a8; wd[1] = 32'h885a308d; wd[2] = 32'h313198a2; wd[3] = 32'he0370734;
    axi_write(8'h21, 32'h10, 3, 3'd2, 2'b01, 3, resp);
    prev = done_seen;
    wd[0] = 32'h3; ws[0] = 4'hf;
    axi_write(8'h22, 32'h20, 0, 3'd2, 2'b01, 0, resp);
    wait_core(prev);
    chk("start_count", n_starts, 1);
    chk("start_key", cap_key, SpecKey);
    chk("start_text", cap_text, SpecText);
    chk("start_enc", cap_enc, 1'b1);
    axi_read(8'h23, 32'h24, 0, 3'd2, 2'b01, rd, rr);
    chk("status_done", rd, 32'h2);
    axi_read(8'h24, 32'h30, 3, 3'd2, 2'b01, rd, rr);
    chk("tout_word0", rd, 32'h3925841d);

    // Writes while BUSY are rejected
    core_lat = 40;
    prev = done_seen;
    wd[0] = 32'h3;
    axi_write(8'h30, 32'h20, 0, 3'd2, 2'b01, 0, resp);
    wd[0] = 32'hffffffff;
    axi_write(8'h31, 32'h0, 0, 3'd2, 2'b01, 0, resp);
    chk("busy_key_slverr", resp, 2'b10);
    wd[0] = 32'h1;
    axi_write(8'h32, 32'h20, 0, 3'd2, 2'b01, 0, resp);
    chk("busy_ctrl_slverr", resp, 2'b10);
    wait_core(prev);
    chk("busy_start_count", n_starts, 2);
    chk("start_pulse_width", wide_pulses, 0);
    axi_read(8'h33, 32'h0, 0, 3'd2, 2'b01, rd, rr);
    chk("busy_key_kept", rd, 32'h2b7e1516);

    // CORE_DONE while idle is ignored
    stray_req++;
    repeat (3) @(posedge ACLK);
    #1;
    axi_read(8'h34, 32'h30, 0, 3'd2, 2'b01, rd, rr);
    chk("stray_done_tout", rd, 32'h3925841d);

    // Illegal size, WRAP burst, early and missing WLAST
    wd[0] = 32'h12345678; wd[1] = 32'h9abcdef0; ws[0] = 4'hf; ws[1] = 4'hf;
    axi_write(8'h40, 32'h0, 0, 3'd1, 2'b01, 0, resp);
    chk("size_slverr", resp, 2'b10);
    axi_write(8'h41, 32'h0, 0, 3'd2, 2'b10, 0, resp);
    chk("wrap_slverr", resp, 2'b10);
    axi_read(8'h42, 32'h0, 0, 3'd2, 2'b01, rd, rr);
    chk("err_key_kept", rd, 32'h2b7e1516);
    axi_write(8'h43, 32'h28, 1, 3'd2, 2'b01, 0, resp);
    chk("early_wlast_slverr", resp, 2'b10);
    axi_write(8'h44, 32'h28, 1, 3'd2, 2'b01, -1, resp);
    chk("missing_wlast_slverr", resp, 2'b10);
    axi_read(8'h45, 32'h0, 0, 3'd1, 2'b01, rd, rr);
    chk("rd_size_slverr", rr, 2'b10);

    // Table of single-beat write / read-back pairs
    for (int i = 0; i < 10; i++) begin
      wd[0] = vecs[i].data; ws[0] = vecs[i].strb;
      axi_write(8'h50 + 8'(i), vecs[i].addr, 0, 3'd2, 2'b01, 0, resp);
      chk($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
      axi_read(8'h60 + 8'(i), vecs[i].addr, 0, 3'd2, 2'b01, rd, rr);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Randomised bursts against the model
    for (int it = 0; it < 40; it++) begin
      int len, start;
      logic [1:0] bt;
      logic [3:0] ridx;
      len   = $urandom_range(0, 3);
      start = $urandom_range(0, 7 - len);
      bt    = 2'($urandom_range(0, 1));
      for (int b = 0; b <= len; b++) begin
        wd[b] = $urandom();
        ws[b] = 4'($urandom_range(0, 15));
      end
      axi_write(8'($urandom()), ($urandom() & 32'hffffffc0) | 32'(start * 4), len, 3'd2, bt,
                len, resp);
      ridx = 4'($urandom_range(0, 15));
      axi_read(8'($urandom()), ($urandom() & 32'hffffffc0) | {26'd0, ridx, 2'b00},
               $urandom_range(0, 7), 3'd2, 2'($urandom_range(0, 1)), rd, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
